main_mem_resp: RTL and testbench

Main-memory responder that sits behind the data cache (`data_mem_sys`) and serves its miss traffic. On a read request it fetches the whole 4-word block containing the requested word and returns it as a burst. On a write request it commits a single write-through word. Both operations complete after a programmable access latency. The block is the far end of the cache's refill/write-through interface, and the source of the multi-cycle delay that the cache converts into core `Stall`.

---
 rtl/main_mem_resp_if.sv | 28 ++
 rtl/main_mem_resp.sv | 155 +++++++++++++++
 tb/tb_main_mem_resp.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_resp_if.sv
// Request/response bundle between the data cache and the main-memory responder.
// The cache drives the request side (master). The responder drives Ready,
// the read burst and the write completion (slave).
interface main_mem_resp_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  Req;
    logic                  ReqWrite;
    logic [ADDR_WIDTH-1:0] ReqAddr;
    logic [DATA_WIDTH-1:0] ReqData;
    logic                  Ready;
    logic                  RespValid;
    logic [DATA_WIDTH-1:0] RespData;
    logic [1:0]            RespWordIdx;
    logic                  RespLast;
    logic                  WriteDone;

    modport master (
        output Req, ReqWrite, ReqAddr, ReqData,
        input  Ready, RespValid, RespData, RespWordIdx, RespLast, WriteDone
    );

    modport slave (
        input  Req, ReqWrite, ReqAddr, ReqData,
        output Ready, RespValid, RespData, RespWordIdx, RespLast, WriteDone
    );
endinterface

// File: rtl/main_mem_resp.sv
// Main-memory responder behind the data cache.
// A read returns the whole 4-word block as a burst in word order 0..3, after
// READ_LATENCY cycles. A write commits one word after WRITE_LATENCY cycles and
// pulses WriteDone. There is no queue: one request is in flight at a time.
module main_mem_resp #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic              CLK,
    input  logic              RST,
    main_mem_resp_if.slave    bus
);

    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // The counter only ever holds values up to LAT_MAX-1.
    localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_WAIT  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            idx_q;
    logic [1:0]            idx_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_last_q;
    logic                  write_done_q;
    logic                  mem_we_d;

    // Not cleared by reset: it is the memory contents, not control state.
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Index arithmetic is 2 bits wide so the burst stays inside its block.
    assign idx_d    = idx_q + 2'd1;
    // The write commits on the same edge that ends the WriteDone cycle.
    assign mem_we_d = (state_q == WR_WAIT) && (cnt_q == CNT_W'(0)) && !RST;

    // Request sequencing and registered response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            base_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_last_q  <= 1'b0;
                    resp_data_q  <= '0;
                    idx_q        <= 2'd0;
                    write_done_q <= 1'b0;
                    if (bus.Req) begin
                        if (bus.ReqWrite) begin
                            wr_addr_q    <= bus.ReqAddr;
                            wr_data_q    <= bus.ReqData;
                            cnt_q        <= CNT_W'(WRITE_LATENCY - 1);
                            // With a one-cycle latency the done pulse is the very next cycle.
                            write_done_q <= (WRITE_LATENCY == 1);
                            state_q      <= WR_WAIT;
                        end else begin
                            base_q <= {bus.ReqAddr[ADDR_WIDTH-1:2], 2'b00};
                            if (READ_LATENCY == 1) begin
                                cnt_q        <= '0;
                                resp_valid_q <= 1'b1;
                                resp_data_q  <= mem[{bus.ReqAddr[ADDR_WIDTH-1:2], 2'b00}];
                                state_q      <= RD_BURST;
                            end else begin
                                cnt_q   <= CNT_W'(READ_LATENCY - 1);
                                state_q <= RD_WAIT;
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_WAIT: begin
                    // Leaving on count 1 makes word 0 appear READ_LATENCY cycles after acceptance.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q        <= '0;
                        idx_q        <= 2'd0;
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= 1'b0;
                        resp_data_q  <= mem[base_q];
                        state_q      <= RD_BURST;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RD_BURST: begin
                    if (idx_q == 2'd3) begin
                        idx_q        <= 2'd0;
                        resp_valid_q <= 1'b0;
                        resp_last_q  <= 1'b0;
                        resp_data_q  <= '0;
                        state_q      <= IDLE;
                    end else begin
                        idx_q        <= idx_d;
                        resp_data_q  <= mem[{base_q[ADDR_WIDTH-1:2], idx_d}];
                        resp_last_q  <= (idx_d == 2'd3);
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == CNT_W'(0)) begin
                        write_done_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q        <= cnt_q - CNT_W'(1);
                        write_done_q <= (cnt_q == CNT_W'(1));
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    idx_q        <= 2'd0;
                    resp_valid_q <= 1'b0;
                    resp_last_q  <= 1'b0;
                    resp_data_q  <= '0;
                    write_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Write-through commit into the array; a reset in the done cycle drops it.
    always_ff @(posedge CLK) begin
        if (mem_we_d) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    assign bus.Ready       = (state_q == IDLE) && !RST;
    assign bus.RespValid   = resp_valid_q;
    assign bus.RespData    = resp_data_q;
    assign bus.RespWordIdx = idx_q;
    assign bus.RespLast    = resp_last_q;
    assign bus.WriteDone   = write_done_q;

endmodule

// File: tb/tb_main_mem_resp.sv
// Directed bench for main_mem_resp: one instance with 4-cycle latencies and
// one with 1-cycle latencies. Outputs are sampled on the falling edge.
module tb_main_mem_resp;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    main_mem_resp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus0 ();
    main_mem_resp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();

    main_mem_resp #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(4), .WRITE_LATENCY(4))
        dut0 (.CLK(CLK), .RST(RST), .bus(bus0.slave));
    main_mem_resp #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_LATENCY(1))
        dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));

    typedef struct {
        logic             wr;
        logic [9:0]       addr;
        logic [31:0]      data;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic o_ready(input bit sel);  return sel ? bus1.Ready : bus0.Ready; endfunction
    function automatic logic o_valid(input bit sel);  return sel ? bus1.RespValid : bus0.RespValid; endfunction
    function automatic logic o_last(input bit sel);   return sel ? bus1.RespLast : bus0.RespLast; endfunction
    function automatic logic o_wdone(input bit sel);  return sel ? bus1.WriteDone : bus0.WriteDone; endfunction
    function automatic logic [31:0] o_data(input bit sel); return sel ? bus1.RespData : bus0.RespData; endfunction
    function automatic logic [1:0] o_idx(input bit sel);   return sel ? bus1.RespWordIdx : bus0.RespWordIdx; endfunction

    task automatic drive(input bit sel, input logic req, input logic wr, input logic [9:0] addr, input logic [31:0] data);
        if (sel) begin
            bus1.Req = req; bus1.ReqWrite = wr; bus1.ReqAddr = addr; bus1.ReqData = data;
        end else begin
            bus0.Req = req; bus0.ReqWrite = wr; bus0.ReqAddr = addr; bus0.ReqData = data;
        end
    endtask

    task automatic add(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.exp = {e3, e2, e1, e0};
        tbl.push_back(v);
    endtask

    // Issues one request from a falling edge with the responder idle and checks
    // every output cycle by cycle until Ready returns.
    task automatic do_op(input bit sel, input logic wr, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0][31:0] exp, input string tag);
        int rl;
        int wl;
        rl = sel ? 1 : 4;
        wl = sel ? 1 : 4;
        chk($sformatf("%s.ready_at_issue", tag), 32'(o_ready(sel)), 32'd1);
        drive(sel, 1'b1, wr, addr, data);
        @(posedge CLK);
        if (wr) begin
            for (int k = 1; k <= wl + 1; k++) begin
                @(negedge CLK);
                if (k == 1) drive(sel, 1'b0, 1'b0, 10'd0, 32'd0);
                chk($sformatf("%s.c%0d.wdone", tag, k), 32'(o_wdone(sel)), 32'(k == wl));
                chk($sformatf("%s.c%0d.ready", tag, k), 32'(o_ready(sel)), 32'(k == wl + 1));
                chk($sformatf("%s.c%0d.valid", tag, k), 32'(o_valid(sel)), 32'd0);
            end
        end else begin
            for (int k = 1; k <= rl + 4; k++) begin
                @(negedge CLK);
                if (k == 1) drive(sel, 1'b0, 1'b0, 10'd0, 32'd0);
                chk($sformatf("%s.c%0d.ready", tag, k), 32'(o_ready(sel)), 32'(k == rl + 4));
                chk($sformatf("%s.c%0d.valid", tag, k), 32'(o_valid(sel)), 32'(k >= rl && k <= rl + 3));
                chk($sformatf("%s.c%0d.last", tag, k), 32'(o_last(sel)), 32'(k == rl + 3));
                chk($sformatf("%s.c%0d.wdone", tag, k), 32'(o_wdone(sel)), 32'd0);
                if (k >= rl && k <= rl + 3) begin
                    chk($sformatf("%s.c%0d.data", tag, k), o_data(sel), exp[k - rl]);
                    chk($sformatf("%s.c%0d.idx", tag, k), 32'(o_idx(sel)), 32'(k - rl));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);

        // Reset and idle behaviour.
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("rst%0d.ready", c), 32'(bus0.Ready), 32'd0);
            chk($sformatf("rst%0d.valid", c), 32'(bus0.RespValid), 32'd0);
            chk($sformatf("rst%0d.last", c), 32'(bus0.RespLast), 32'd0);
            chk($sformatf("rst%0d.wdone", c), 32'(bus0.WriteDone), 32'd0);
            chk($sformatf("rst%0d.data", c), bus0.RespData, 32'd0);
            chk($sformatf("rst%0d.idx", c), 32'(bus0.RespWordIdx), 32'd0);
        end
        RST = 1'b0;
        #1;
        chk("rel.ready0", 32'(bus0.Ready), 32'd1);
        chk("rel.ready1", 32'(bus1.Ready), 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk($sformatf("idle%0d.ready", c), 32'(bus0.Ready), 32'd1);
            chk($sformatf("idle%0d.quiet", c),
                32'({bus0.RespValid, bus0.RespLast, bus0.WriteDone}), 32'd0);
        end

        // Preloads, block reads, write-through followed by read, overwrite.
        add(1'b1, 10'h040, 32'h0000_00A0, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h041, 32'h0000_00A1, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h042, 32'h0000_00A2, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h043, 32'h0000_00A3, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b0, 10'h042, 32'd0, 32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3);
        add(1'b1, 10'h104, 32'h0104_0000, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h106, 32'h0106_0000, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h107, 32'h0107_0000, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h105, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b0, 10'h104, 32'd0, 32'h0104_0000, 32'hDEAD_BEEF, 32'h0106_0000, 32'h0107_0000);
        add(1'b1, 10'h041, 32'h0000_BBBB, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b0, 10'h043, 32'd0, 32'h0000_00A0, 32'h0000_BBBB, 32'h0000_00A2, 32'h0000_00A3);
        for (int a = 0; a < 4; a++) add(1'b1, 10'(16 + a), 32'h1000_0010 + 32'(a), 32'd0, 32'd0, 32'd0, 32'd0);
        for (int a = 1; a < 4; a++) add(1'b1, 10'(32 + a), 32'h0000_0020 + 32'(a), 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 10'h030, 32'h0000_5555, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int a = 1; a < 4; a++) add(1'b1, 10'(48 + a), 32'h0000_0030 + 32'(a), 32'd0, 32'd0, 32'd0, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            do_op(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Busy rejection: a write held on Req during a read is taken only after RespLast.
        drive(1'b0, 1'b1, 1'b0, 10'h010, 32'd0);
        @(posedge CLK);
        for (int k = 1; k <= 13; k++) begin
            @(negedge CLK);
            if (k == 1) drive(1'b0, 1'b1, 1'b1, 10'h020, 32'h00C0_FFEE);
            if (k == 9) drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
            chk($sformatf("busy.c%0d.ready", k), 32'(bus0.Ready), 32'(k == 8 || k == 13));
            chk($sformatf("busy.c%0d.valid", k), 32'(bus0.RespValid), 32'(k >= 4 && k <= 7));
            chk($sformatf("busy.c%0d.wdone", k), 32'(bus0.WriteDone), 32'(k == 12));
            if (k >= 4 && k <= 7) begin
                chk($sformatf("busy.c%0d.data", k), bus0.RespData, 32'h1000_0010 + 32'(k - 4));
            end
        end
        do_op(1'b0, 1'b0, 10'h022, 32'd0,
              {32'h0000_0023, 32'h0000_0022, 32'h0000_0021, 32'h00C0_FFEE}, "busy_rd");

        // Reset two cycles into a write: the write is dropped.
        drive(1'b0, 1'b1, 1'b1, 10'h030, 32'h0000_1234);
        @(posedge CLK);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        chk("rstwr.c1.wdone", 32'(bus0.WriteDone), 32'd0);
        @(negedge CLK);
        chk("rstwr.c2.wdone", 32'(bus0.WriteDone), 32'd0);
        RST = 1'b1;
        #1;
        chk("rstwr.c2.ready", 32'(bus0.Ready), 32'd0);
        @(negedge CLK);
        chk("rstwr.c3.wdone", 32'(bus0.WriteDone), 32'd0);
        chk("rstwr.c3.ready", 32'(bus0.Ready), 32'd0);
        RST = 1'b0;
        #1;
        chk("rstwr.c3.ready_rel", 32'(bus0.Ready), 32'd1);
        for (int k = 4; k <= 6; k++) begin
            @(negedge CLK);
            chk($sformatf("rstwr.c%0d.wdone", k), 32'(bus0.WriteDone), 32'd0);
            chk($sformatf("rstwr.c%0d.ready", k), 32'(bus0.Ready), 32'd1);
        end
        do_op(1'b0, 1'b0, 10'h030, 32'd0,
              {32'h0000_0033, 32'h0000_0032, 32'h0000_0031, 32'h0000_5555}, "rstwr_rd");

        // One-cycle latency instance: top block, no wrap to address 0.
        for (int a = 0; a < 4; a++) begin
            do_op(1'b1, 1'b1, 10'(a), 32'h0000_BAD0 + 32'(a), '0, $sformatf("l1_lo%0d", a));
            do_op(1'b1, 1'b1, 10'(1020 + a), 32'h03FC_0000 + 32'(a), '0, $sformatf("l1_hi%0d", a));
        end
        do_op(1'b1, 1'b0, 10'h3FF, 32'd0,
              {32'h03FC_0003, 32'h03FC_0002, 32'h03FC_0001, 32'h03FC_0000}, "l1_rd");

        // Reset in the middle of a burst: outputs clear, no RespLast.
        drive(1'b1, 1'b1, 1'b0, 10'h3FC, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        chk("rstrd.c1.valid", 32'(bus1.RespValid), 32'd1);
        chk("rstrd.c1.data", bus1.RespData, 32'h03FC_0000);
        @(negedge CLK);
        chk("rstrd.c2.idx", 32'(bus1.RespWordIdx), 32'd1);
        chk("rstrd.c2.data", bus1.RespData, 32'h03FC_0001);
        RST = 1'b1;
        @(negedge CLK);
        chk("rstrd.c3.valid", 32'(bus1.RespValid), 32'd0);
        chk("rstrd.c3.last", 32'(bus1.RespLast), 32'd0);
        chk("rstrd.c3.data", bus1.RespData, 32'd0);
        chk("rstrd.c3.idx", 32'(bus1.RespWordIdx), 32'd0);
        RST = 1'b0;
        for (int k = 4; k <= 5; k++) begin
            @(negedge CLK);
            chk($sformatf("rstrd.c%0d.quiet", k),
                32'({bus1.RespValid, bus1.RespLast, bus1.WriteDone}), 32'd0);
            chk($sformatf("rstrd.c%0d.ready", k), 32'(bus1.Ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
